// File: rtl/d_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, sign fix-up afterwards, one-cycle register-file write strobe.
module d_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] busw,
  output logic [4:0]      rw,
  output logic            we
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     a_q, b_q, res_q;
  logic [2*XLEN-1:0]   prod_q;
  logic                neg_res_q, neg_rem_q;

  logic                a_signed, b_signed, div0, ovf, special, accept;
  logic [XLEN-1:0]     a_mag, b_mag, spec_res;
  logic [XLEN:0]       mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix;

  assign busy = (state_q != IDLE);

  always_comb begin
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_mag    = (a_signed && opa[XLEN-1]) ? -opa : opa;
    b_mag    = (b_signed && opb[XLEN-1]) ? -opb : opb;
    div0     = funct3[2] && (opb == '0);
    ovf      = funct3[2] && !funct3[0] && (opa == SMIN) && (opb == '1);
    special  = div0 || ovf;
    accept   = (state_q == IDLE) && start && !flush;
    if (div0) spec_res = funct3[1] ? opa : '1;
    else      spec_res = funct3[1] ? '0 : SMIN;
  end

  // Multiply: add multiplicand into the upper half when multiplier LSB is set, then shift right.
  // Divide: {rem,quot} share prod_q; shift left, trial-subtract, keep on non-negative result.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    rem_sh   = prod_q[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, b_q};
    prod_fix = neg_res_q ? -prod_q : prod_q;
    quot_fix = neg_res_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: begin
        if (flush)                          state_d = IDLE;
        else if (cnt_q == CW'(XLEN - 1))    state_d = FIX;
      end
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busw      <= '0;
      rw        <= '0;
      done      <= 1'b0;
      we        <= 1'b0;
    end else begin
      done <= (state_q == DONE);
      we   <= (state_q == DONE) && (rw != '0);
      if (state_q == DONE) busw <= res_q;
      unique case (state_q)
        IDLE: if (accept) begin
          op_q      <= funct3;
          a_q       <= a_mag;
          b_q       <= b_mag;
          rw        <= rd;
          cnt_q     <= '0;
          neg_res_q <= (a_signed && opa[XLEN-1]) ^ (b_signed && opb[XLEN-1]);
          neg_rem_q <= a_signed && opa[XLEN-1];
          prod_q    <= funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          res_q     <= spec_res;
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (!op_q[2])     prod_q <= {mul_sum, prod_q[XLEN-1:1]};
          else if (!diff[XLEN]) prod_q <= {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
          else              prod_q <= {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end
        FIX: begin
          if (!op_q[2])      res_q <= (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          else if (op_q[1])  res_q <= rem_fix;
          else               res_q <= quot_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_muldiv_unit.sv
// Directed-vector bench for d_muldiv_unit: latency, results, write strobe, flush and reset.
module tb_d_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, we;
  logic [31:0] busw;
  logic [4:0]  rw;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .opa(opa), .opb(opb), .rd(rd), .busy(busy), .done(done), .busw(busw),
    .rw(rw), .we(we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a clock edge; returns the number of edges from accept to done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input bit poke, output int lat,
                        output logic [31:0] bw, output logic wev, output logic [4:0] rwv);
    funct3 = f; opa = a; opb = b; rd = r; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 99; bw = 32'hDEAD_BEEF; wev = 1'bx; rwv = 5'bx;
    for (int n = 1; n <= 40; n++) begin
      if (poke && (n == 5 || n == 20)) begin
        start = 1'b1; opa = 32'h9; opb = 32'h9; funct3 = 3'd3; rd = 5'd7;
      end
      @(posedge clk); #1 start = 1'b0;
      if (done) begin
        lat = n; bw = busw; wev = we; rwv = rw;
        break;
      end
    end
  endtask

  int          lat;
  logic [31:0] bw;
  logic        wev;
  logic [4:0]  rwv;
  bit          saw_done;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busw", busw, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 1'b0, lat, bw, wev, rwv);
    chk("mul_lat", lat, 32'd34);
    chk("mul_res", bw, 32'hFFFF_FFEB);
    chk("mul_we", {31'b0, wev}, 32'd1);
    chk("mul_rw", {27'b0, rwv}, 32'd5);
    chk("mul_idle", {31'b0, busy}, 32'd0);

    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0, lat, bw, wev, rwv);
    chk("mulhu", bw, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0, lat, bw, wev, rwv);
    chk("mulh", bw, 32'h0000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 1'b0, lat, bw, wev, rwv);
    chk("mulhsu", bw, 32'hFFFF_FFFF);

    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd2, 1'b0, lat, bw, wev, rwv);
    chk("div_lat", lat, 32'd34);
    chk("div", bw, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd2, 1'b0, lat, bw, wev, rwv);
    chk("rem", bw, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 5'd2, 1'b0, lat, bw, wev, rwv);
    chk("divu", bw, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 5'd2, 1'b0, lat, bw, wev, rwv);
    chk("remu", bw, 32'd2);

    run_op(3'd4, 32'd1234, 32'd0, 5'd3, 1'b0, lat, bw, wev, rwv);
    chk("div0_lat", lat, 32'd1);
    chk("div0", bw, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b0, lat, bw, wev, rwv);
    chk("removf_lat", lat, 32'd1);
    chk("removf", bw, 32'h0000_0000);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b0, lat, bw, wev, rwv);
    chk("divovf", bw, 32'h8000_0000);
    run_op(3'd7, 32'd5, 32'd0, 5'd3, 1'b0, lat, bw, wev, rwv);
    chk("remu0", bw, 32'd5);

    run_op(3'd0, 32'd3, 32'd4, 5'd0, 1'b1, lat, bw, wev, rwv);
    chk("rd0_lat", lat, 32'd34);
    chk("rd0_res", bw, 32'd12);
    chk("rd0_we", {31'b0, wev}, 32'd0);
    chk("rd0_rw", {27'b0, rwv}, 32'd0);

    // Flush at cycle 10 of a divide: busy drops, no done, busw keeps 12.
    funct3 = 3'd5; opa = 32'd100; opb = 32'd7; rd = 5'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || we) saw_done = 1'b1;
    end
    chk("flush_nodone", {31'b0, saw_done}, 32'd0);
    chk("flush_busw", busw, 32'd12);

    start = 1'b1; flush = 1'b1; funct3 = 3'd0;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("flush_idle", {31'b0, busy}, 32'd0);

    // Flush landing in DONE still commits the write.
    funct3 = 3'd5; opa = 32'd77; opb = 32'd0; rd = 5'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flushdone_done", {31'b0, done}, 32'd1);
    chk("flushdone_we", {31'b0, we}, 32'd1);
    chk("flushdone_busw", busw, 32'hFFFF_FFFF);

    funct3 = 3'd4; opa = 32'd1000; opb = 32'd3; rd = 5'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_busw", busw, 32'd0);
    chk("midrst_rw", {27'b0, rw}, 32'd0);
    chk("midrst_we", {31'b0, we}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || we || busy) saw_done = 1'b1;
    end
    chk("midrst_quiet", {31'b0, saw_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
